// File: rtl/fifo_rdarb_pkg.sv
// Shared types and constants for the FIFO read-port arbiter.
package fifo_rdarb_pkg;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam int unsigned CNT_W         = 16;
  localparam int unsigned NUM_REQ_DEF   = 4;
  localparam int unsigned BURST_LEN_DEF = 4;
  localparam int unsigned MAX_REQ       = 8;

  // Index of the set bit in a one-hot vector; 0 when the vector is all-zero.
  function automatic logic [2:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_REQ); i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible request at or after start, with wrap.
module rr_pick
  import fifo_rdarb_pkg::*;
#(
  parameter int unsigned N = NUM_REQ_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  input  logic [N-1:0]         excl,
  output logic [N-1:0]         win,
  output logic                 found
);

  logic [N-1:0] cand;

  assign cand = req & ~excl;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (!found && cand[j] && (j == (int'(start) + i) % int'(N))) begin
          win[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO read port among NUM_REQ consumers.
// Optional per-consumer pop counters on rd_cnt when FIFO_RDARB_STATS_EN is defined.
module fifo_rd_arbiter
  import fifo_rdarb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic               rclk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               empty,
  output logic               r_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] rd_valid,
  output logic               busy
`ifdef FIFO_RDARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] rd_cnt
`endif
);

  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  localparam int unsigned BurstW = $clog2(BURST_LEN + 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, rd_valid_q;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [IdxW-1:0]     owner, base, start;
  logic [NUM_REQ-1:0]  excl, win;
  logic                found, own_req, rel_a, rel_b;

  assign owner   = IdxW'(onehot_idx(MAX_REQ'(gnt_q)));
  assign own_req = |(req & gnt_q);
  assign busy    = (state_q == StGrant);
  assign r_en    = busy & own_req & ~empty;
  assign rel_b   = ~own_req;
  assign rel_a   = r_en && ((int'(burst_q) + 1) == int'(BURST_LEN));

  // A burst-limit release scans from owner+1, so the owner wins only when alone.
  assign base  = busy ? owner : last_q;
  assign start = (int'(base) == int'(NUM_REQ) - 1) ? '0 : base + 1'b1;
  assign excl  = (busy && rel_b) ? gnt_q : '0;

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req  (req),
    .start(start),
    .excl (excl),
    .win  (win),
    .found(found)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    burst_d = burst_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gnt_d   = win;
          burst_d = '0;
        end
      end
      StGrant: begin
        if (rel_a || rel_b) begin
          last_d = owner;
          if (found) begin
            gnt_d   = win;
            burst_d = '0;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end else if (r_en) begin
          burst_d = burst_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      burst_q    <= '0;
      last_q     <= IdxW'(NUM_REQ - 1);
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      burst_q    <= burst_d;
      last_q     <= last_d;
      rd_valid_q <= r_en ? gnt_q : '0;
    end
  end

  assign gnt      = gnt_q;
  assign rd_valid = rd_valid_q;

`ifdef FIFO_RDARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_cnt
    always_ff @(posedge rclk) begin
      if (reset) begin
        cnt_q[g] <= '0;
      end else if (r_en && gnt_q[g]) begin
        cnt_q[g] <= cnt_q[g] + 1'b1;
      end
    end
    assign rd_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: reference model plus rd_valid scoreboard.
module tb_fifo_rd_arbiter;

  localparam int N  = 4;
  localparam int BL = 4;

  logic         rclk = 1'b0;
  logic         reset, empty, r_en, busy;
  logic [N-1:0] req, gnt, rd_valid;
`ifdef FIFO_RDARB_STATS_EN
  logic [N*16-1:0] rd_cnt;
`endif

  always #5 rclk = ~rclk;

  fifo_rd_arbiter #(
    .NUM_REQ  (N),
    .BURST_LEN(BL)
  ) dut (
    .rclk    (rclk),
    .reset   (reset),
    .req     (req),
    .empty   (empty),
    .r_en    (r_en),
    .gnt     (gnt),
    .rd_valid(rd_valid),
    .busy    (busy)
`ifdef FIFO_RDARB_STATS_EN
    ,
    .rd_cnt  (rd_cnt)
`endif
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [3:0]  sb_q[$];

  int          m_state, m_owner, m_last, m_burst;
  logic [15:0] m_cnt [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] m_gnt();
    return (m_state == 1) ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  function automatic int pick(input logic [3:0] r, input int after, input int excl);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (after + k) % N;
      if (((r >> idx) & 4'b0001) != 4'b0000 && idx != excl) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_owner = 0;
    m_last  = N - 1;
    m_burst = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
  endtask

  // Check one cycle's outputs, then advance the model across the next edge.
  task automatic cyc();
    logic [3:0] exp_rv;
    logic       own, m_ren, rel_a, rel_b;
    int         w;
    #3;
    own   = ((req >> m_owner) & 4'b0001) != 4'b0000;
    m_ren = (m_state == 1) && own && !empty;
    chk("gnt", 64'(gnt), 64'(m_gnt()));
    chk("busy", 64'(busy), 64'(m_state == 1));
    chk("r_en", 64'(r_en), 64'(m_ren));
    exp_rv = sb_q.pop_front();
    chk("rd_valid", 64'(rd_valid), 64'(exp_rv));
    chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
    if (r_en) chk("no_over_read", 64'(empty), 64'd0);
`ifdef FIFO_RDARB_STATS_EN
    for (int i = 0; i < N; i++) chk("rd_cnt", 64'(rd_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
    if (reset) begin
      model_reset();
      sb_q.push_back(4'b0000);
    end else begin
      sb_q.push_back(m_ren ? m_gnt() : 4'b0000);
      if (m_ren) m_cnt[m_owner] = m_cnt[m_owner] + 16'd1;
      if (m_state == 0) begin
        w = pick(req, m_last, -1);
        if (w >= 0) begin
          m_state = 1;
          m_owner = w;
          m_burst = 0;
        end
      end else begin
        rel_b = !own;
        rel_a = m_ren && (m_burst + 1 == BL);
        if (rel_a || rel_b) begin
          m_last = m_owner;
          w = pick(req, m_owner, rel_b ? m_owner : -1);
          if (w >= 0) begin
            m_owner = w;
            m_burst = 0;
          end else begin
            m_state = 0;
          end
        end else if (m_ren) begin
          m_burst++;
        end
      end
    end
    @(posedge rclk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    empty = 1'b0;
    model_reset();
    @(posedge rclk);
    #1;
    sb_q.push_back(4'b0000);
    cyc();
    cyc();
    chk("reset_gnt", 64'(gnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    // Single consumer: regranted with no bubble.
    reset = 1'b0;
    req   = 4'b0001;
    cyc();
    chk("single_first_gnt", 64'(gnt), 64'b0001);
    repeat (12) cyc();
    chk("single_rv", 64'(rd_valid), 64'b0001);

    // Fairness rotation.
    req = 4'b1111;
    repeat (40) cyc();

    // Empty stall mid-burst on owner 2.
    reset = 1'b1;
    req   = '0;
    cyc();
    reset = 1'b0;
    req   = 4'b0100;
    cyc();
    cyc();
    cyc();
    empty = 1'b1;
    repeat (5) cyc();
    chk("stall_gnt", 64'(gnt), 64'b0100);
    chk("stall_ren", 64'(r_en), 64'd0);
    empty = 1'b0;
    repeat (4) cyc();

    // Early drop by owner 1 hands over to 3.
    reset = 1'b1;
    req   = '0;
    cyc();
    reset = 1'b0;
    req   = 4'b1010;
    cyc();
    chk("drop_first_gnt", 64'(gnt), 64'b0010);
    cyc();
    req = 4'b1000;
    cyc();
    chk("drop_gnt", 64'(gnt), 64'b1000);
    chk("drop_rv", 64'(rd_valid), 64'b0000);
    repeat (2) cyc();

    // Reset one cycle after a pop.
    reset = 1'b1;
    cyc();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rv", 64'(rd_valid), 64'd0);
    reset = 1'b0;
    req   = 4'b1111;
    cyc();
    chk("rst_regrant", 64'(gnt), 64'b0001);
    repeat (6) cyc();

    // Random traffic.
    repeat (10000) begin
      req   = 4'($urandom);
      empty = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 499) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
